// File: rtl/driver_config_sequencer.sv
// rtl/driver_config_sequencer.sv - writes configuration words into daisy-chained LED driver control registers
module driver_config_sequencer #(
    parameter int                      CONFIG_WIDTH   = 48,
    parameter int                      NB_DRIVERS     = 2,
    parameter logic [CONFIG_WIDTH-1:0] DEFAULT_CONFIG = 48'h0000_0000_00FF,
    parameter bit                      AUTOLOAD       = 1'b1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [CONFIG_WIDTH-1:0] config_in,
    input  logic                    new_config,
    input  logic                    bus_grant,
    output logic                    bus_req,
    output logic                    drv_sclk,
    output logic                    drv_lat,
    output logic                    drv_sin,
    output logic                    busy,
    output logic                    config_applied,
    output logic [CONFIG_WIDTH-1:0] applied_config
);

    localparam int TOTAL_BITS = NB_DRIVERS * CONFIG_WIDTH;
    localparam int FC_PULSES  = 15;
    localparam int LAT_BITS   = 5;
    localparam int CNT_MAX    = (TOTAL_BITS > FC_PULSES) ? TOTAL_BITS : FC_PULSES;
    // One spare count so the counter reaches TOTAL_BITS after the last bit without wrapping
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FC_LAST   = CNT_W'(FC_PULSES - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0] LAT_START = CNT_W'(TOTAL_BITS - LAT_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FCWRTEN,
        S_GAP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    phase;
    logic [CNT_W-1:0]        cnt;
    logic [CONFIG_WIDTH-1:0] shift_word;
    logic [CONFIG_WIDTH-1:0] pending_word;
    logic                    pending;

    logic req_d;
    logic sclk_d;
    logic lat_d;
    logic sin_d;
    logic applied_d;

    assign busy = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the bus levels to present on the following cycle
    always_comb begin
        state_nxt = state;
        req_d     = 1'b0;
        sclk_d    = 1'b0;
        lat_d     = 1'b0;
        sin_d     = 1'b0;
        applied_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) state_nxt = S_REQ;
            end
            S_REQ: begin
                req_d = 1'b1;
                if (bus_grant) state_nxt = S_FCWRTEN;
            end
            S_FCWRTEN: begin
                req_d  = 1'b1;
                lat_d  = 1'b1;
                sclk_d = phase;
                if (phase && cnt == FC_LAST) state_nxt = S_GAP;
            end
            S_GAP: begin
                req_d = 1'b1;
                if (phase) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                req_d  = 1'b1;
                sclk_d = phase;
                sin_d  = shift_word[CONFIG_WIDTH-1];
                lat_d  = (cnt >= LAT_START);
                if (phase && cnt == LAST_BIT) state_nxt = S_DONE;
            end
            S_DONE: begin
                applied_d = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase/bit counters and the word being shifted; rotating by one per bit
    // returns the word to its original value after NB_DRIVERS full passes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase      <= 1'b0;
            cnt        <= '0;
            shift_word <= DEFAULT_CONFIG;
        end else begin
            case (state)
                S_IDLE: begin
                    phase <= 1'b0;
                    cnt   <= '0;
                    if (pending) shift_word <= new_config ? config_in : pending_word;
                end
                S_FCWRTEN: begin
                    phase <= ~phase;
                    if (phase) cnt <= (cnt == FC_LAST) ? '0 : cnt + CNT_W'(1);
                end
                S_GAP: begin
                    phase <= ~phase;
                end
                S_WRITE: begin
                    phase <= ~phase;
                    if (phase) begin
                        cnt        <= cnt + CNT_W'(1);
                        shift_word <= {shift_word[CONFIG_WIDTH-2:0], shift_word[CONFIG_WIDTH-1]};
                    end
                end
                default: begin
                    phase <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Single-entry update queue; the newest word always replaces an older pending one
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending      <= AUTOLOAD;
            pending_word <= DEFAULT_CONFIG;
        end else begin
            if (new_config) pending_word <= config_in;
            if (state == S_IDLE && pending) begin
                pending <= 1'b0;
            end else if (new_config) begin
                pending <= 1'b1;
            end
        end
    end

    // Record the word once every driver has latched it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            applied_config <= DEFAULT_CONFIG;
        end else if (state == S_DONE) begin
            applied_config <= shift_word;
        end
    end

    // Registered bus outputs keep the driver lines glitch-free
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus_req        <= 1'b0;
            drv_sclk       <= 1'b0;
            drv_lat        <= 1'b0;
            drv_sin        <= 1'b0;
            config_applied <= 1'b0;
        end else begin
            bus_req        <= req_d;
            drv_sclk       <= sclk_d;
            drv_lat        <= lat_d;
            drv_sin        <= sin_d;
            config_applied <= applied_d;
        end
    end

endmodule

// File: tb/tb_driver_config_sequencer.sv
// tb/tb_driver_config_sequencer.sv - self-checking bench for driver_config_sequencer
module tb_driver_config_sequencer;

    localparam int          CW  = 48;
    localparam int          NB  = 2;
    localparam logic [47:0] DEF = 48'h0000_0000_00FF;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [CW-1:0] config_in = '0;
    logic          new_config = 1'b0;
    logic          bus_grant = 1'b0;
    logic          bus_req;
    logic          drv_sclk;
    logic          drv_lat;
    logic          drv_sin;
    logic          busy;
    logic          config_applied;
    logic [CW-1:0] applied_config;

    driver_config_sequencer #(
        .CONFIG_WIDTH   (CW),
        .NB_DRIVERS     (NB),
        .DEFAULT_CONFIG (DEF),
        .AUTOLOAD       (1'b1)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .config_in      (config_in),
        .new_config     (new_config),
        .bus_grant      (bus_grant),
        .bus_req        (bus_req),
        .drv_sclk       (drv_sclk),
        .drv_lat        (drv_lat),
        .drv_sin        (drv_sin),
        .busy           (busy),
        .config_applied (config_applied),
        .applied_config (applied_config)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] data;
        logic [95:0] lat;
        int          fc;
        int          fc_bad;
        int          nbits;
        logic [47:0] applied;
    } rec_t;

    rec_t        got_q[$];
    logic [47:0] exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    int          pulses = 0;
    int          fc_cnt = 0;
    int          fc_bad = 0;
    int          dcnt = 0;
    int          inv_err = 0;
    logic [95:0] dbuf = '0;
    logic [95:0] lbuf = '0;
    logic        prev_sclk = 1'b0;

    // Serial bus monitor: first 15 SCLK pulses are the write-enable, the rest data bits
    always @(negedge clk) begin
        prev_sclk <= drv_sclk;
        if (bus_req === 1'b0 && (drv_sclk | drv_lat | drv_sin) === 1'b1) inv_err <= inv_err + 1;
        if (!nrst || config_applied === 1'b1) begin
            if (nrst) got_q.push_back(rec_t'{data: dbuf, lat: lbuf, fc: fc_cnt, fc_bad: fc_bad,
                                             nbits: dcnt, applied: applied_config});
            pulses <= 0;
            fc_cnt <= 0;
            fc_bad <= 0;
            dcnt   <= 0;
            dbuf   <= '0;
            lbuf   <= '0;
        end else if (drv_sclk === 1'b1 && prev_sclk === 1'b0) begin
            pulses <= pulses + 1;
            if (pulses < 15) begin
                fc_cnt <= fc_cnt + 1;
                if (drv_lat !== 1'b1 || drv_sin !== 1'b0) fc_bad <= fc_bad + 1;
            end else begin
                dbuf <= {dbuf[94:0], drv_sin};
                lbuf <= {lbuf[94:0], drv_lat};
                dcnt <= dcnt + 1;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_config(input logic [47:0] w);
        config_in  = w;
        new_config = 1'b1;
        tick;
        new_config = 1'b0;
    endtask

    task automatic wait_record(input int budget, output rec_t r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() > 0) begin
                r  = got_q.pop_front();
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rec_t        r;
        bit          ok;
        logic [47:0] w;
        nrst = 1'b0;
        bus_grant = 1'b1;
        repeat (3) tick;
        total_cnt++;
        if ({bus_req, drv_sclk, drv_lat, drv_sin, config_applied, busy} !== 6'b0)
            $display("FAIL reset_outputs: got %b required 000000",
                     {bus_req, drv_sclk, drv_lat, drv_sin, config_applied, busy});
        else pass_cnt++;
        total_cnt++;
        if (applied_config !== DEF) $display("FAIL reset_applied: got %h required %h", applied_config, DEF);
        else pass_cnt++;
        exp_q.push_back(DEF);
        nrst = 1'b1;
        tick;
        total_cnt++;
        if (bus_req !== 1'b0) $display("FAIL req_rise_1clk: got %b required 0", bus_req);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (bus_req !== 1'b1) $display("FAIL req_rise_2clk: got %b required 1", bus_req);
        else pass_cnt++;
        wait_record(400, r, ok);
        w = exp_q.pop_front();
        total_cnt++;
        if (!ok) $display("FAIL autoload_seq: no config_applied within 400 clk");
        else if (r.data !== {w, w} || r.lat !== 96'h1F || r.fc != 15 || r.fc_bad != 0 || r.nbits != 96 || r.applied !== w)
            $display("FAIL autoload_seq: data=%h lat=%h fc=%0d fc_bad=%0d bits=%0d applied=%h required data=%h lat=1f fc=15 bits=96 applied=%h",
                     r.data, r.lat, r.fc, r.fc_bad, r.nbits, r.applied, {w, w}, w);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (config_applied !== 1'b0) $display("FAIL applied_pulse_width: got %b required 0", config_applied);
        else pass_cnt++;
        repeat (20) tick;
        total_cnt++;
        if (got_q.size() != 0 || busy !== 1'b0 || applied_config !== DEF)
            $display("FAIL autoload_once: extra=%0d busy=%b applied=%h required 0 0 %h",
                     got_q.size(), busy, applied_config, DEF);
        else pass_cnt++;
    endtask

    task automatic test_grant_wait;
        rec_t        r;
        bit          ok;
        bit          bad;
        int          k;
        logic [47:0] w;
        bus_grant = 1'b0;
        tick;
        exp_q.push_back(48'hA5A5_0F0F_1234);
        pulse_config(48'hA5A5_0F0F_1234);
        k = 0;
        while (bus_req !== 1'b1 && k < 10) begin tick; k++; end
        total_cnt++;
        if (bus_req !== 1'b1) $display("FAIL req_wait: bus_req=%b required 1 within 10 clk", bus_req);
        else pass_cnt++;
        bad = 1'b0;
        repeat (50) begin
            tick;
            if (bus_req !== 1'b1 || {drv_sclk, drv_lat, drv_sin} !== 3'b0) bad = 1'b1;
        end
        total_cnt++;
        if (bad) $display("FAIL hold_no_grant: got bus activity or req drop, required req=1 bus=000");
        else pass_cnt++;
        bus_grant = 1'b1;
        k = 0;
        do begin tick; k++; end while (config_applied !== 1'b1 && k < 400);
        total_cnt++;
        if (k != 226) $display("FAIL grant_latency: got %0d clk required 226", k);
        else pass_cnt++;
        wait_record(5, r, ok);
        w = exp_q.pop_front();
        total_cnt++;
        if (!ok) $display("FAIL grant_seq: no record");
        else if (r.data !== {w, w} || r.lat !== 96'h1F || r.fc != 15 || r.fc_bad != 0 || r.nbits != 96 || r.applied !== w)
            $display("FAIL grant_seq: data=%h lat=%h fc=%0d fc_bad=%0d bits=%0d applied=%h required data=%h lat=1f fc=15 bits=96 applied=%h",
                     r.data, r.lat, r.fc, r.fc_bad, r.nbits, r.applied, {w, w}, w);
        else pass_cnt++;
    endtask

    task automatic test_pending_overwrite;
        rec_t        r;
        bit          ok;
        int          k;
        logic [47:0] w;
        bus_grant = 1'b1;
        tick;
        exp_q.push_back(48'h3);
        pulse_config(48'h3);
        k = 0;
        while (dcnt < 10 && k < 200) begin tick; k++; end
        total_cnt++;
        if (dcnt < 10) $display("FAIL write_start: bits=%0d required >=10", dcnt);
        else pass_cnt++;
        pulse_config(48'h1);
        tick;
        exp_q.push_back(48'h2);
        pulse_config(48'h2);
        for (int s = 0; s < 2; s++) begin
            wait_record(400, r, ok);
            w = exp_q.pop_front();
            total_cnt++;
            if (!ok) $display("FAIL overwrite_seq%0d: no record", s);
            else if (r.data !== {w, w} || r.lat !== 96'h1F || r.fc != 15 || r.fc_bad != 0 || r.nbits != 96 || r.applied !== w)
                $display("FAIL overwrite_seq%0d: data=%h lat=%h fc=%0d bits=%0d applied=%h required data=%h applied=%h",
                         s, r.data, r.lat, r.fc, r.nbits, r.applied, {w, w}, w);
            else pass_cnt++;
        end
        repeat (300) tick;
        total_cnt++;
        if (got_q.size() != 0 || busy !== 1'b0)
            $display("FAIL overwrite_extra: extra=%0d busy=%b required 0 0", got_q.size(), busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write;
        rec_t        r;
        bit          ok;
        int          k;
        logic        req_before;
        logic [47:0] w;
        bus_grant = 1'b1;
        pulse_config(48'hDEAD_BEEF_CAFE);
        k = 0;
        while (dcnt < 40 && k < 200) begin tick; k++; end
        req_before = bus_req;
        nrst = 1'b0;
        #1;
        total_cnt++;
        if (req_before !== 1'b1 || dcnt < 40 || {bus_req, drv_sclk, drv_lat, drv_sin, config_applied} !== 5'b0)
            $display("FAIL async_abort: req_before=%b bits=%0d outs=%b required 1 >=40 00000",
                     req_before, dcnt, {bus_req, drv_sclk, drv_lat, drv_sin, config_applied});
        else pass_cnt++;
        total_cnt++;
        if (applied_config !== DEF) $display("FAIL abort_applied: got %h required %h", applied_config, DEF);
        else pass_cnt++;
        repeat (2) tick;
        exp_q.push_back(DEF);
        nrst = 1'b1;
        wait_record(400, r, ok);
        w = exp_q.pop_front();
        total_cnt++;
        if (!ok) $display("FAIL reload_seq: no record");
        else if (r.data !== {w, w} || r.lat !== 96'h1F || r.fc != 15 || r.fc_bad != 0 || r.nbits != 96 || r.applied !== w)
            $display("FAIL reload_seq: data=%h lat=%h fc=%0d bits=%0d applied=%h required data=%h applied=%h",
                     r.data, r.lat, r.fc, r.nbits, r.applied, {w, w}, w);
        else pass_cnt++;
    endtask

    task automatic test_grant_drop;
        rec_t        r;
        bit          ok;
        int          k;
        logic [47:0] w;
        bus_grant = 1'b1;
        tick;
        exp_q.push_back(48'h0123_4567_89AB);
        pulse_config(48'h0123_4567_89AB);
        k = 0;
        while (fc_cnt < 5 && k < 60) begin tick; k++; end
        total_cnt++;
        if (fc_cnt < 5) $display("FAIL fc_start: pulses=%0d required >=5", fc_cnt);
        else pass_cnt++;
        bus_grant = 1'b0;
        wait_record(400, r, ok);
        w = exp_q.pop_front();
        total_cnt++;
        if (!ok) $display("FAIL grant_drop_seq: no record");
        else if (r.data !== {w, w} || r.lat !== 96'h1F || r.fc != 15 || r.fc_bad != 0 || r.nbits != 96 || r.applied !== w)
            $display("FAIL grant_drop_seq: data=%h lat=%h fc=%0d fc_bad=%0d bits=%0d applied=%h required data=%h fc=15 bits=96 applied=%h",
                     r.data, r.lat, r.fc, r.fc_bad, r.nbits, r.applied, {w, w}, w);
        else pass_cnt++;
        bus_grant = 1'b1;
        repeat (3) tick;
    endtask

    task automatic test_done_same_cycle;
        rec_t        r;
        bit          ok;
        int          k;
        logic [47:0] w;
        bus_grant = 1'b1;
        exp_q.push_back(48'h0000_1111_2222);
        pulse_config(48'h0000_1111_2222);
        k = 0;
        while (dcnt != 96 && k < 400) begin tick; k++; end
        exp_q.push_back(48'h0000_3333_4444);
        pulse_config(48'h0000_3333_4444);
        total_cnt++;
        if (config_applied !== 1'b1 || bus_req !== 1'b0)
            $display("FAIL done_edge: applied=%b req=%b required 1 0", config_applied, bus_req);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (bus_req !== 1'b0) $display("FAIL done_gap: req=%b required 0", bus_req);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (bus_req !== 1'b1) $display("FAIL done_rereq: req=%b required 1", bus_req);
        else pass_cnt++;
        for (int s = 0; s < 2; s++) begin
            wait_record(400, r, ok);
            w = exp_q.pop_front();
            total_cnt++;
            if (!ok) $display("FAIL done_seq%0d: no record", s);
            else if (r.data !== {w, w} || r.lat !== 96'h1F || r.fc != 15 || r.fc_bad != 0 || r.nbits != 96 || r.applied !== w)
                $display("FAIL done_seq%0d: data=%h lat=%h fc=%0d bits=%0d applied=%h required data=%h applied=%h",
                         s, r.data, r.lat, r.fc, r.nbits, r.applied, {w, w}, w);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_grant_wait;
        test_pending_overwrite;
        test_reset_mid_write;
        test_grant_drop;
        test_done_same_cycle;
        repeat (5) tick;
        total_cnt++;
        if (inv_err != 0) $display("FAIL bus_idle_invariant: violations=%0d required 0", inv_err);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
